// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ       number of requesters
//   ID_W        width of a requester index
//   HOLD_W      width of the grant hold counter
//   arb_state_t arbiter FSM states
//   id_onehot   index -> one-hot grant vector
package arb_pkg;

   localparam int N_REQ  = 4;
   localparam int ID_W   = 2;
   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
      return N_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Rotating-priority encoder: searches req starting at ptr, wrapping mod 4,
// and returns the index of the first set bit.
//   req     request lines
//   ptr     index with highest priority
//   win_id  index of the winning requester (don't care when any = 0)
//   any     at least one request is set
module rr_prio_enc4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  win_id,
   output logic             any
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [ID_W-1:0]    off;

   always_comb begin
      // rot[i] = req[(ptr + i) mod 4], so the lowest set bit of rot is the
      // smallest offset from ptr
      dbl = {req, req};
      rot = dbl[{1'b0, ptr} +: N_REQ];
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = ID_W'(i);
      end
      win_id = off + ptr;
      any    = |req;
   end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with a programmable hold limit.
//   MAX_HOLD   maximum consecutive grant cycles per winner (0 = unlimited)
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   req        level-sensitive request lines
//   gnt        registered one-hot grant
//   gnt_id     registered index of the granted requester
//   gnt_valid  registered OR of gnt
//   timeout    one-cycle pulse when a grant was removed by the hold limit
//
// state   | meaning
// IDLE    | no grant; arbitrate every cycle
// GRANT   | gnt_id owns the resource; hold_cnt counts grant cycles
// RELEASE | one-cycle turnaround with gnt = 0; ptr already advanced, arbitrate
module arbiter_rr4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state;
   logic [ID_W-1:0]   ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic [ID_W-1:0]   win_id;
   logic              win_any;
   logic              hold_last;

   rr_prio_enc4 u_enc (
      .req    (req),
      .ptr    (ptr),
      .win_id (win_id),
      .any    (win_any)
   );

   assign hold_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE, RELEASE: begin
               if (win_any) begin
                  state     <= GRANT;
                  gnt_id    <= win_id;
                  gnt       <= id_onehot(win_id);
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               // a request dropping on the last allowed cycle is a normal
               // release, so the req check comes before the hold limit
               if (!req[gnt_id] || hold_last) begin
                  state     <= RELEASE;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  ptr       <= gnt_id + 2'd1;
                  timeout   <= req[gnt_id];
               end
               // saturate so an unlimited hold never wraps the counter
               if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
            end
            default: begin
               state     <= IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbiter_rr4.sv
module tb_arbiter_rr4;

   localparam int ND = 3;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] gnt [ND];
   logic [1:0] gnt_id [ND];
   logic       gnt_valid [ND];
   logic       timeout [ND];

   int n_chk  = 0;
   int n_fail = 0;

   // hold limits of the three instances
   int mh [ND] = '{4, 0, 1};

   arbiter_rr4 #(.MAX_HOLD(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .req(req),
      .gnt(gnt[0]), .gnt_id(gnt_id[0]), .gnt_valid(gnt_valid[0]), .timeout(timeout[0])
   );
   arbiter_rr4 #(.MAX_HOLD(0)) dut_z (
      .clk(clk), .reset_n(reset_n), .req(req),
      .gnt(gnt[1]), .gnt_id(gnt_id[1]), .gnt_valid(gnt_valid[1]), .timeout(timeout[1])
   );
   arbiter_rr4 #(.MAX_HOLD(1)) dut_o (
      .clk(clk), .reset_n(reset_n), .req(req),
      .gnt(gnt[2]), .gnt_id(gnt_id[2]), .gnt_valid(gnt_valid[2]), .timeout(timeout[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // owner = -1 means nobody holds the resource; len = grant cycles completed
   int m_owner [ND];
   int m_len   [ND];
   int m_ptr   [ND];
   bit m_to    [ND];

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_owner[d] = -1;
         m_len[d]   = 0;
         m_ptr[d]   = 0;
         m_to[d]    = 1'b0;
      end
   endtask

   task automatic model_step(input logic [3:0] r);
      for (int d = 0; d < ND; d++) begin
         if (m_owner[d] >= 0) begin
            m_len[d]++;
            if (!r[m_owner[d]]) begin
               m_ptr[d]   = (m_owner[d] + 1) % 4;
               m_owner[d] = -1;
               m_to[d]    = 1'b0;
            end else if (mh[d] != 0 && m_len[d] == mh[d]) begin
               m_ptr[d]   = (m_owner[d] + 1) % 4;
               m_owner[d] = -1;
               m_to[d]    = 1'b1;
            end
         end else begin
            m_to[d] = 1'b0;
            if (r != 4'b0) begin
               m_owner[d] = pick(r, m_ptr[d]);
               m_len[d]   = 0;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [3:0] g;
      for (int d = 0; d < ND; d++) begin
         g = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
         check($sformatf("model gnt dut%0d", d), gnt[d], g);
         check($sformatf("model gnt_valid dut%0d", d), 4'(gnt_valid[d]), 4'(g != 4'b0));
         check($sformatf("model timeout dut%0d", d), 4'(timeout[d]), 4'(m_to[d]));
         if (m_owner[d] >= 0)
            check($sformatf("model gnt_id dut%0d", d), 4'(gnt_id[d]), 4'(m_owner[d]));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("%s gnt dut%0d", tag, d), gnt[d], 4'b0000);
         check($sformatf("%s gnt_id dut%0d", tag, d), 4'(gnt_id[d]), 4'd0);
         check($sformatf("%s gnt_valid dut%0d", tag, d), 4'(gnt_valid[d]), 4'd0);
         check($sformatf("%s timeout dut%0d", tag, d), 4'(timeout[d]), 4'd0);
      end
   endtask

   // one clock: drive req, step the model at the edge, compare at the falling edge
   task automatic cycle(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
      compare_all();
   endtask

   // ---------------- directed vectors for dut_a (MAX_HOLD = 4) ----------------
   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       to;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [3:0] r, input logic [3:0] g,
                               input logic [1:0] id, input logic to);
      vec_t v;
      v.req = r; v.gnt = g; v.id = id; v.to = to;
      tbl.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      logic [3:0] flip;
      logic [1:0] gi;

      // single requester, then release and ptr advance
      add(4'b0001, 4'b0001, 2'd0, 1'b0);
      add(4'b0001, 4'b0001, 2'd0, 1'b0);
      add(4'b0000, 4'b0000, 2'd0, 1'b0);   // release cycle
      add(4'b0000, 4'b0000, 2'd0, 1'b0);   // idle, ptr = 1
      add(4'b0011, 4'b0010, 2'd1, 1'b0);   // ptr = 1 favours requester 1
      add(4'b0011, 4'b0010, 2'd1, 1'b0);
      add(4'b0001, 4'b0000, 2'd0, 1'b0);   // 1 drops, ptr = 2
      add(4'b0011, 4'b0001, 2'd0, 1'b0);   // search 2,3,0: 0 wins over 1
      add(4'b0010, 4'b0000, 2'd0, 1'b0);   // 0 drops, ptr = 1
      add(4'b0010, 4'b0010, 2'd1, 1'b0);   // 1 granted next
      add(4'b1000, 4'b0000, 2'd0, 1'b0);   // 1 drops, ptr = 2
      add(4'b1000, 4'b1000, 2'd3, 1'b0);   // requester 3: grant cycles 1..4
      add(4'b1000, 4'b1000, 2'd3, 1'b0);
      add(4'b1000, 4'b1000, 2'd3, 1'b0);
      add(4'b1000, 4'b1000, 2'd3, 1'b0);
      add(4'b0000, 4'b0000, 2'd0, 1'b0);   // drop on last allowed cycle: no timeout
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      // all requesting: 0,1,2,3,0, each 4 cycles then a timeout turnaround
      for (int g = 0; g < 5; g++) begin
         gi = 2'(g % 4);
         for (int c = 0; c < 4; c++) add(4'b1111, 4'(1 << gi), gi, 1'b0);
         add(4'b1111, 4'b0000, 2'd0, 1'b1);
      end
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      // lead-in to the reset-mid-grant sequence (ptr = 1, only 2 asking)
      add(4'b0100, 4'b0100, 2'd2, 1'b0);
      add(4'b0100, 4'b0100, 2'd2, 1'b0);

      // reset
      req     = 4'b0000;
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_vals("reset");
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].req);
         check($sformatf("vec%0d gnt", i), gnt[0], tbl[i].gnt);
         check($sformatf("vec%0d timeout", i), 4'(timeout[0]), 4'(tbl[i].to));
         if (tbl[i].gnt != 4'b0000)
            check($sformatf("vec%0d gnt_id", i), 4'(gnt_id[0]), 4'(tbl[i].id));
      end

      // reset asserted mid-grant: outputs clear at once, no timeout pulse
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reset_vals("async reset");
      @(negedge clk);
      check_reset_vals("held reset");
      reset_n = 1'b1;
      cycle(4'b0110);
      check("post-reset grant picks 1", gnt[0], 4'b0010);
      cycle(4'b0110);

      // unlimited hold: requester 1 keeps the grant
      for (int c = 0; c < 300; c++) begin
         cycle(4'b0010);
         check("no-limit continuous gnt", gnt[1], 4'b0010);
         check("no-limit timeout", 4'(timeout[1]), 4'd0);
      end

      // randomized sticky requests against the model
      r = 4'b0000;
      for (int c = 0; c < 800; c++) begin
         flip = 4'b0000;
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(3) == 0);
         r = r ^ flip;
         cycle(r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
